pe_array_feeder: RTL and testbench



---
 rtl/pe_array_feeder.sv | 92 +++++++++
 tb/tb_pe_array_feeder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_feeder.sv
// Feeds a systolic PE array from a valid/ready stream and collects its results.
// Steps are credit-gated so every in-flight element has a guaranteed FIFO slot.
module pe_array_feeder #(
    parameter int ELEMENT_BITS = 8,
    parameter int P            = 4,
    parameter int LAT          = 2 * P - 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                            sys_clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic [ELEMENT_BITS-1:0]         in_data,
    output logic                            in_ready,
    input  logic                            flush,
    output logic                            pe_step,
    output logic [ELEMENT_BITS-1:0]         array_data_out,
    input  logic [ELEMENT_BITS-1:0]         array_result,
    output logic                            res_valid,
    output logic [ELEMENT_BITS-1:0]         res_data,
    input  logic                            res_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            idle
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    logic [LAT-1:0]          r_tag;
    logic [CW-1:0]           r_inflight;
    logic [CW-1:0]           r_count;
    logic [AW-1:0]           r_wptr;
    logic [AW-1:0]           r_rptr;
    logic [ELEMENT_BITS-1:0] r_data_out;
    logic [ELEMENT_BITS-1:0] r_mem [FIFO_DEPTH];

    logic [CW:0] w_used;
    logic        w_credit_ok;
    logic        w_run;
    logic        w_step;
    logic        w_accept;
    logic        w_capture;
    logic        w_pop;

    // Credit counts both queued and in-flight results; a pop frees credit next cycle.
    assign w_used      = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_credit_ok = (w_used < DEPTH_C);
    assign w_run       = w_credit_ok & ~reset;
    assign w_step      = w_run & (in_valid | (flush & (r_inflight != '0)));
    assign w_accept    = in_valid & w_run;
    assign w_capture   = w_step & r_tag[LAT-1];
    assign w_pop       = (r_count != '0) & res_ready;

    assign in_ready       = w_run;
    assign pe_step        = w_step;
    assign array_data_out = r_data_out;
    assign res_valid      = (r_count != '0);
    assign res_data       = res_valid ? r_mem[r_rptr] : '0;
    assign fifo_count     = r_count;
    assign idle           = (r_inflight == '0) & (r_count == '0);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_tag      <= '0;
            r_inflight <= '0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_data_out <= '0;
        end else begin
            if (w_step) begin
                r_data_out <= w_accept ? in_data : '0;
                r_tag      <= {r_tag[LAT-2:0], w_accept};
            end
            case ({w_accept, w_capture})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
            if (w_capture) r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            case ({w_capture, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_capture) r_mem[r_wptr] <= array_result;
    end
endmodule

// File: tb/tb_pe_array_feeder.sv
// Bench for pe_array_feeder: delay-line array model returning element+1,
// queue scoreboard for result order, vector table plus corner-case sequences.
module tb_pe_array_feeder;
    localparam int EB    = 8;
    localparam int LAT   = 7;
    localparam int DEPTH = 8;

    logic          sys_clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [EB-1:0] in_data;
    logic          in_ready;
    logic          flush;
    logic          pe_step;
    logic [EB-1:0] array_data_out;
    logic [EB-1:0] array_result;
    logic          res_valid;
    logic [EB-1:0] res_data;
    logic          res_ready;
    logic [3:0]    fifo_count;
    logic          idle;

    pe_array_feeder #(.ELEMENT_BITS(EB), .P(4), .LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .sys_clk        (sys_clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .flush          (flush),
        .pe_step        (pe_step),
        .array_data_out (array_data_out),
        .array_result   (array_result),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .res_ready      (res_ready),
        .fifo_count     (fifo_count),
        .idle           (idle)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioral array: LAT-step delay line advanced by pe_step, result = element+1
    logic [EB-1:0] pipe [LAT-1];
    always @(posedge sys_clk) begin
        if (pe_step) begin
            pipe[0] <= array_data_out;
            for (int k = 1; k < LAT - 1; k++) pipe[k] <= pipe[k-1];
        end
    end
    assign array_result = pipe[LAT-2] + 8'd1;

    int checks = 0;
    int errors = 0;
    int n_step = 0;
    int n_pop  = 0;
    int n_rv   = 0;
    logic [EB-1:0] q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle
    always @(negedge sys_clk) begin
        if (!reset) begin
            if (pe_step) n_step++;
            if (res_valid) n_rv++;
            if (res_valid && res_ready) begin
                n_pop++;
                if (q.size() == 0) begin
                    chk("unexpected result", {24'h0, res_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("result order", {24'h0, res_data}, {24'h0, q.pop_front()});
                end
            end
            if (in_valid && in_ready) q.push_back(in_data + 8'd1);
            chk("fifo bound", 32'(fifo_count <= 4'(DEPTH)), 1);
            chk("credit bound", 32'(q.size() <= DEPTH), 1);
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [EB-1:0] d, input logic fl, input logic rr);
        in_valid  = v;
        in_data   = d;
        flush     = fl;
        res_ready = rr;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!idle && n < 200) begin
            tick();
            n++;
        end
        chk(name, 32'(idle), 1);
    endtask

    task automatic wait_count(input string name, input int target);
        int n;
        n = 0;
        while (fifo_count != 4'(target) && n < 200) begin
            tick();
            n++;
        end
        chk(name, 32'(fifo_count), 32'(target));
    endtask

    typedef struct {
        logic          v;
        logic [EB-1:0] d;
        logic          fl;
        logic          rr;
        logic          e_step;
        logic          e_rv;
        logic [EB-1:0] e_rd;
        logic          e_idle;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0, p0, rv0, acc, b;
        logic rdy;

        tbl[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
        for (int i = 1; i < 8; i++)
            tbl[i] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};

        reset = 1'b1;
        drive(1'b1, 8'hAA, 1'b1, 1'b1);
        @(negedge sys_clk);
        chk("rst in_ready", 32'(in_ready), 0);
        chk("rst pe_step", 32'(pe_step), 0);
        chk("rst res_valid", 32'(res_valid), 0);
        chk("rst res_data", 32'(res_data), 0);
        chk("rst fifo_count", 32'(fifo_count), 0);
        chk("rst array_data_out", 32'(array_data_out), 0);
        chk("rst idle", 32'(idle), 1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        tick();

        // Single element drained by flush
        s0 = n_step;
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].fl, tbl[i].rr);
            @(negedge sys_clk);
            chk("t1 pe_step", 32'(pe_step), 32'(tbl[i].e_step));
            chk("t1 res_valid", 32'(res_valid), 32'(tbl[i].e_rv));
            chk("t1 res_data", 32'(res_data), 32'(tbl[i].e_rd));
            chk("t1 idle", 32'(idle), 32'(tbl[i].e_idle));
            tick();
        end
        chk("t1 step count", n_step - s0, 8);

        // Sixteen streamed elements, downstream always ready
        p0 = n_pop;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b1);
            b = 0;
            @(negedge sys_clk);
            rdy = in_ready;
            if (i < 8) chk("t2 early ready", 32'(rdy), 1);
            tick();
            while (!rdy && b < 50) begin
                @(negedge sys_clk);
                rdy = in_ready;
                tick();
                b++;
            end
            if (!rdy) chk("t2 accept timeout", 0, 1);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        wait_idle("t2 drain");
        chk("t2 pops", n_pop - p0, 16);
        chk("t2 queue empty", q.size(), 0);

        // Downstream stalled: credit caps accepts at FIFO_DEPTH
        acc = 0;
        p0 = n_pop;
        for (int c = 0; c < 12; c++) begin
            drive(1'b1, 8'h40 + 8'(acc), 1'b0, 1'b0);
            @(negedge sys_clk);
            if (in_ready) acc++;
            tick();
        end
        chk("t3 accepts", acc, 8);
        @(negedge sys_clk);
        chk("t3 in_ready low", 32'(in_ready), 0);
        chk("t3 no step", 32'(pe_step), 0);
        chk("t3 fifo_count", 32'(fifo_count), 1);
        chk("t3 outstanding", q.size(), 8);
        repeat (5) tick();
        chk("t3 outstanding held", q.size(), 8);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        wait_idle("t3 drain");
        chk("t3 pops", n_pop - p0, 8);

        // Simultaneous push and pop at fifo_count=3
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h20 + 8'(i), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        wait_count("t4 fill", 3);
        drive(1'b1, 8'h23, 1'b1, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (6) tick();
        res_ready = 1'b1;
        @(negedge sys_clk);
        chk("t4 step", 32'(pe_step), 1);
        chk("t4 head before", 32'(res_data), 32'h21);
        tick();
        res_ready = 1'b0;
        @(negedge sys_clk);
        chk("t4 count held", 32'(fifo_count), 3);
        chk("t4 head after", 32'(res_data), 32'h22);
        tick();
        res_ready = 1'b1;
        wait_idle("t4 drain");

        // Frozen array with no flush
        p0 = n_pop;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h50 + 8'(i), 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        s0 = n_step;
        rv0 = n_rv;
        repeat (20) tick();
        chk("t5 no step", n_step - s0, 0);
        chk("t5 no result", n_rv - rv0, 0);
        chk("t5 in flight", q.size(), 3);
        flush = 1'b1;
        wait_idle("t5 drain");
        chk("t5 pops", n_pop - p0, 3);

        // Reset with results in flight and queued
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'h60 + 8'(i), 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        wait_count("t6 queued", 2);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 8'h7F, 1'b1, 1'b1);
        chk("t6 outstanding", q.size(), 5);
        #2;
        reset = 1'b1;
        #1;
        chk("t6 in_ready", 32'(in_ready), 0);
        chk("t6 pe_step", 32'(pe_step), 0);
        chk("t6 res_valid", 32'(res_valid), 0);
        chk("t6 res_data", 32'(res_data), 0);
        chk("t6 fifo_count", 32'(fifo_count), 0);
        chk("t6 array_data_out", 32'(array_data_out), 0);
        chk("t6 idle", 32'(idle), 1);
        q.delete();
        tick();
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        reset = 1'b0;
        s0 = n_step;
        rv0 = n_rv;
        repeat (20) tick();
        chk("t6 no step", n_step - s0, 0);
        chk("t6 no result", n_rv - rv0, 0);
        chk("t6 idle after", 32'(idle), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
